letc_tb_ctrl: RTL and testbench

Synthesisable simulation controller for LETC nonuvm benches: sequences the DUT's reset, counts run cycles, watches per-channel done/fail probes with a watchdog timeout, and reports a single pass/fail verdict. It replaces hand-written clock/reset/`repeat` loops in bench `initial` blocks. The bench drives `clk`/`rst_n` and calls `$finish` when `finished` rises. It generalises the fixed "reset for one step, run N toggles" pattern to parametrised reset length, timeout, drain window and channel count.

---
 rtl/letc_tb_pkg.sv | 12 +
 rtl/letc_tb_sat_counter.sv | 21 ++
 rtl/letc_tb_ctrl.sv | 139 +++++++++++++
 tb/tb_letc_tb_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/letc_tb_pkg.sv
// Shared types for the LETC bench controller.
package letc_tb_pkg;

    // Controller phases, encoded as exposed on the state output.
    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } tb_ctrl_state_e;

endpackage

// File: rtl/letc_tb_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module letc_tb_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    // Count up while enabled; hold once every bit is set.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/letc_tb_ctrl.sv
// Bench controller: sequences DUT reset, counts run cycles, watches per-channel
// done/fail probes under a watchdog, and produces a single pass/fail verdict.
module letc_tb_ctrl
    import letc_tb_pkg::*;
#(
    parameter int RESET_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int DRAIN_CYCLES   = 8,
    parameter int NUM_CH         = 2,
    parameter int CNT_W          = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_done,
    input  logic [NUM_CH-1:0] ch_fail,
    input  logic              abort,
    output logic              dut_rst_n,
    output logic [CNT_W-1:0]  cycle_count,
    output tb_ctrl_state_e    state,
    output logic [NUM_CH-1:0] fail_mask,
    output logic              timed_out,
    output logic              finished,
    output logic              passed
);

    // Hold/drain counters only need to reach their last value (param - 1).
    localparam int HOLD_W  = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES);
    localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);

    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [NUM_CH-1:0]  done_seen;
    logic               aborted;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [DRAIN_W-1:0] drain_cnt;

    logic [NUM_CH-1:0]  done_nx;
    logic [NUM_CH-1:0]  fail_nx;
    logic               abort_nx;
    logic               exit_hit;
    logic               timeout_hit;
    logic               drain_pass;

    // Run-cycle counter: advances through RUN and DRAIN, frozen elsewhere.
    letc_tb_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (1'b0),
        .enable ((state == RUN) || (state == DRAIN)),
        .count  (cycle_count)
    );

    letc_tb_sat_counter #(.W(HOLD_W)) u_hold_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (1'b0),
        .enable (state == HOLD),
        .count  (hold_cnt)
    );

    letc_tb_sat_counter #(.W(DRAIN_W)) u_drain_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (1'b0),
        .enable (state == DRAIN),
        .count  (drain_cnt)
    );

    // Next-cycle views of the sticky flags, so this cycle's inputs count toward
    // both the exit decision and the verdict latched on entering DONE.
    always_comb begin
        done_nx     = done_seen | ch_done;
        fail_nx     = fail_mask | ch_fail;
        abort_nx    = aborted | abort;
        exit_hit    = (&done_nx) || (|fail_nx) || abort;
        // Exit condition takes priority over the watchdog in the same cycle.
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cycle_count == TO_LAST) && !exit_hit;
        drain_pass  = (&done_nx) && (fail_nx == '0) && !abort_nx && !timed_out;
    end

    // Controller FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= HOLD;
            dut_rst_n <= 1'b0;
            fail_mask <= '0;
            done_seen <= '0;
            aborted   <= 1'b0;
            timed_out <= 1'b0;
            finished  <= 1'b0;
            passed    <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state     <= RUN;
                        dut_rst_n <= 1'b1;
                    end
                end
                RUN: begin
                    done_seen <= done_nx;
                    fail_mask <= fail_nx;
                    aborted   <= abort_nx;
                    if (exit_hit) begin
                        if (DRAIN_CYCLES == 0) begin
                            state    <= DONE;
                            finished <= 1'b1;
                            passed   <= drain_pass;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (timeout_hit) begin
                        state     <= DONE;
                        timed_out <= 1'b1;
                        finished  <= 1'b1;
                        passed    <= 1'b0;
                    end
                end
                DRAIN: begin
                    done_seen <= done_nx;
                    fail_mask <= fail_nx;
                    aborted   <= abort_nx;
                    if (drain_cnt == DRAIN_LAST) begin
                        state    <= DONE;
                        finished <= 1'b1;
                        passed   <= drain_pass;
                    end
                end
                default: begin
                    // DONE: terminal until reset.
                    finished <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_letc_tb_ctrl.sv
// Directed bench for letc_tb_ctrl: default instance, a 50-cycle watchdog
// instance, and a 4-bit-counter instance with the watchdog disabled.
module tb_letc_tb_ctrl;
    import letc_tb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [1:0] done_a = '0, fail_a = '0, done_t = '0, fail_t = '0, done_s = '0, fail_s = '0;
    logic       abort_a = 1'b0, abort_t = 1'b0, abort_s = 1'b0;

    logic dr_a, dr_t, dr_s;
    logic [31:0] cnt_a, cnt_t;
    logic [3:0]  cnt_s;
    tb_ctrl_state_e st_a, st_t, st_s;
    logic [1:0] fm_a, fm_t, fm_s;
    logic to_a, to_t, to_s, fin_a, fin_t, fin_s, pass_a, pass_t, pass_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    letc_tb_ctrl u_a (
        .clk(clk), .rst_n(rst_n), .ch_done(done_a), .ch_fail(fail_a), .abort(abort_a),
        .dut_rst_n(dr_a), .cycle_count(cnt_a), .state(st_a), .fail_mask(fm_a),
        .timed_out(to_a), .finished(fin_a), .passed(pass_a)
    );

    letc_tb_ctrl #(.TIMEOUT_CYCLES(50)) u_t (
        .clk(clk), .rst_n(rst_n), .ch_done(done_t), .ch_fail(fail_t), .abort(abort_t),
        .dut_rst_n(dr_t), .cycle_count(cnt_t), .state(st_t), .fail_mask(fm_t),
        .timed_out(to_t), .finished(fin_t), .passed(pass_t)
    );

    letc_tb_ctrl #(.TIMEOUT_CYCLES(0), .CNT_W(4)) u_s (
        .clk(clk), .rst_n(rst_n), .ch_done(done_s), .ch_fail(fail_s), .abort(abort_s),
        .dut_rst_n(dr_s), .cycle_count(cnt_s), .state(st_s), .fail_mask(fm_s),
        .timed_out(to_s), .finished(fin_s), .passed(pass_s)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Phase 1: reset, release, clean completion on A, watchdog on T, saturation on S
        tick(2);
        check("rst_state", 64'(st_a), 64'(HOLD));
        check("rst_dut_rst_n", 64'(dr_a), 64'd0);
        check("rst_cnt", 64'(cnt_a), 64'd0);
        check("rst_flags", {60'd0, fm_a, fin_a, pass_a}, 64'd0);
        check("rst_timed_out", 64'(to_t), 64'd0);

        rst_n = 1'b1;
        tick(3);
        check("hold_dut_rst_n", 64'(dr_a), 64'd0);
        check("hold_state", 64'(st_a), 64'(HOLD));
        tick(1);
        check("run_dut_rst_n", 64'(dr_a), 64'd1);
        check("run_state", 64'(st_a), 64'(RUN));
        check("run_cnt0", 64'(cnt_a), 64'd0);

        tick(10);
        check("cnt10", 64'(cnt_a), 64'd10);
        done_a = 2'b01;
        tick(1);
        done_a = 2'b00;
        check("done0_still_run", 64'(st_a), 64'(RUN));
        tick(9);
        done_a = 2'b10;
        tick(1);
        done_a = 2'b00;
        check("drain_entry", 64'(st_a), 64'(DRAIN));
        check("drain_cnt21", 64'(cnt_a), 64'd21);
        tick(7);
        check("drain_not_fin", 64'(fin_a), 64'd0);
        tick(1);
        check("done_state", 64'(st_a), 64'(DONE));
        check("done_fin", 64'(fin_a), 64'd1);
        check("done_pass", 64'(pass_a), 64'd1);
        check("done_cnt29", 64'(cnt_a), 64'd29);
        tick(3);
        check("cnt_frozen", 64'(cnt_a), 64'd29);

        // T is at run cycle 32 here; walk it to cycle 49
        tick(17);
        check("to_cnt49", 64'(cnt_t), 64'd49);
        check("to_not_fin", 64'(fin_t), 64'd0);
        tick(1);
        check("to_fin", 64'(fin_t), 64'd1);
        check("to_timed_out", 64'(to_t), 64'd1);
        check("to_pass", 64'(pass_t), 64'd0);
        check("to_state", 64'(st_t), 64'(DONE));
        check("sat_cnt15", 64'(cnt_s), 64'd15);
        check("sat_running", 64'(st_s), 64'(RUN));

        // Phase 2: fail pulse on A, done exactly at the watchdog cycle on T
        rst_n = 1'b0;
        tick(1);
        check("rst2_fin", 64'(fin_a), 64'd0);
        check("rst2_timed_out", 64'(to_t), 64'd0);
        check("rst2_cnt", 64'(cnt_t), 64'd0);
        rst_n = 1'b1;
        tick(4);
        check("run2_state", 64'(st_a), 64'(RUN));
        tick(5);
        fail_a = 2'b10;
        tick(1);
        fail_a = 2'b00;
        check("fail_drain", 64'(st_a), 64'(DRAIN));
        check("fail_mask", 64'(fm_a), 64'd2);
        tick(3);
        check("fail_sticky", 64'(fm_a), 64'd2);
        tick(4);
        check("fail_not_fin", 64'(fin_a), 64'd0);
        tick(1);
        check("fail_fin", 64'(fin_a), 64'd1);
        check("fail_pass", 64'(pass_a), 64'd0);
        check("fail_mask_done", 64'(fm_a), 64'd2);

        tick(35);
        check("tie_cnt49", 64'(cnt_t), 64'd49);
        done_t = 2'b11;
        tick(1);
        done_t = 2'b00;
        check("tie_drain", 64'(st_t), 64'(DRAIN));
        check("tie_no_timeout", 64'(to_t), 64'd0);
        tick(8);
        check("tie_fin", 64'(fin_t), 64'd1);
        check("tie_pass", 64'(pass_t), 64'd1);
        check("tie_timed_out", 64'(to_t), 64'd0);

        // Phase 3: abort on A, reset during DRAIN, full sequence repeats
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(6);
        abort_a = 1'b1;
        tick(1);
        abort_a = 1'b0;
        check("abort_drain", 64'(st_a), 64'(DRAIN));
        tick(2);
        rst_n = 1'b0;
        tick(1);
        check("mid_rst_state", 64'(st_a), 64'(HOLD));
        check("mid_rst_dut", 64'(dr_a), 64'd0);
        check("mid_rst_cnt", 64'(cnt_a), 64'd0);
        check("mid_rst_fin", 64'(fin_a), 64'd0);
        rst_n = 1'b1;
        tick(3);
        check("rep_hold", 64'(dr_a), 64'd0);
        tick(1);
        check("rep_run", 64'(dr_a), 64'd1);
        check("rep_cnt0", 64'(cnt_a), 64'd0);
        abort_a = 1'b1;
        tick(1);
        abort_a = 1'b0;
        tick(8);
        check("abort_fin", 64'(fin_a), 64'd1);
        check("abort_pass", 64'(pass_a), 64'd0);
        check("abort_mask", 64'(fm_a), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
